// File: rtl/dbg_seq_pkg.sv
// Shared types and default constants for the debug command sequencer.
package dbg_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RUN,
    ST_WAIT_DONE,
    ST_GAP,
    ST_HALT
  } state_e;

  localparam int DEF_CMD_W       = 5;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_SYNC_STAGES = 4;
  localparam int DEF_PULSE_CYC   = 16;
  localparam int DEF_GAP_CYC     = 8;
  localparam int DEF_TIMEOUT_CYC = 65535;
  localparam int DEF_CNT_W       = 8;
  localparam bit DEF_HALT_ON_ERR = 1'b1;

  // The start bit sits directly above the command code.
  localparam int DEF_START_BIT = DEF_CMD_W;
  function automatic int start_idx(input int cmd_w);
    return cmd_w;
  endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Command FIFO; extra pointer MSB distinguishes full from empty.
module dbg_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic         CLK,
  input  logic         NRST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + (AW+1)'(1);
      if (pop && !empty) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/dbg_cmd_sequencer.sv
// Pops queued debug commands, strobes them to the tester and tracks each
// command through run/done handshakes with timeouts and pass/fail tallies.
module dbg_cmd_sequencer
  import dbg_seq_pkg::*;
#(
  parameter int CMD_W       = DEF_CMD_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit HALT_ON_ERR = DEF_HALT_ON_ERR
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             ENABLE,
  input  logic             CLR,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [CMD_W-1:0] CMD_DATA,
  input  logic             DBGRUNNING,
  input  logic             DBGERROR,
  output logic             PORESETN,
  output logic [CMD_W:0]   DBGCMD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int SB = start_idx(CMD_W);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [CW-1:0]          wcnt_q;
  logic [CMD_W-1:0]       code_q, head;
  logic                   push, pop, full, empty;
  logic                   fin, bad, tmo;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign PORESETN = sync_q[SYNC_STAGES-1];

  assign CMD_READY = PORESETN && !full;
  assign push      = CMD_VALID && CMD_READY;

  dbg_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (push),
    .pop   (pop),
    .wdata (CMD_DATA),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fin     = 1'b0;
    bad     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_RST_WAIT: if (PORESETN) state_d = ST_IDLE;
      ST_IDLE: if (ENABLE && !empty) begin
        pop     = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (wcnt_q == PULSE_LAST) state_d = ST_WAIT_RUN;
      ST_WAIT_RUN: begin
        if (DBGRUNNING) state_d = ST_WAIT_DONE;
        else if (wcnt_q == TO_LAST) begin fin = 1'b1; bad = 1'b1; tmo = 1'b1; end
      end
      ST_WAIT_DONE: begin
        // Completion wins over a timeout landing on the same cycle.
        if (!DBGRUNNING) begin fin = 1'b1; bad = DBGERROR; end
        else if (wcnt_q == TO_LAST) begin fin = 1'b1; bad = 1'b1; tmo = 1'b1; end
      end
      ST_GAP:  if (wcnt_q == GAP_LAST) state_d = ST_IDLE;
      ST_HALT: if (CLR) state_d = ST_IDLE;
      default: state_d = ST_RST_WAIT;
    endcase
    if (fin) state_d = (bad && HALT_ON_ERR) ? ST_HALT : ST_GAP;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_RST_WAIT;
      wcnt_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= (state_d != state_q) ? '0 : wcnt_q + CW'(1);
      if (pop) code_q <= head;
    end
  end

  // CLR takes priority over a completion landing on the same edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      TIMEOUT  <= 1'b0;
      PASS_CNT <= '0;
      FAIL_CNT <= '0;
    end else begin
      DONE <= fin;
      if (CLR) begin
        ERR      <= 1'b0;
        TIMEOUT  <= 1'b0;
        PASS_CNT <= '0;
        FAIL_CNT <= '0;
      end else if (fin) begin
        if (bad) begin
          ERR <= 1'b1;
          if (tmo) TIMEOUT <= 1'b1;
          if (FAIL_CNT != '1) FAIL_CNT <= FAIL_CNT + CNT_W'(1);
        end else if (PASS_CNT != '1) begin
          PASS_CNT <= PASS_CNT + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    DBGCMD            = '0;
    DBGCMD[SB]        = (state_q == ST_ISSUE);
    DBGCMD[CMD_W-1:0] = (state_q == ST_ISSUE) ? code_q : '0;
  end

  assign BUSY = !(state_q inside {ST_RST_WAIT, ST_IDLE});
endmodule

// File: tb/tb_dbg_cmd_sequencer.sv
// Randomised and directed bench for dbg_cmd_sequencer against a queue-based
// behavioural model; an emulated tester answers each command strobe.
module tb_dbg_cmd_sequencer;
  localparam int CMD_W = 5, DEPTH = 8, SYNC = 4, PULSE = 16, GAPC = 8, TO = 100, CNT_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int P_RST = 0, P_IDLE = 1, P_STR = 2, P_RUN = 3, P_DW = 4, P_GAP = 5, P_HALT = 6;

  logic CLK = 1'b0, NRST, ENABLE, CLR, CMD_VALID, CMD_READY, DBGRUNNING, DBGERROR;
  logic PORESETN, BUSY, DONE, ERR, TIMEOUT;
  logic [CMD_W-1:0] CMD_DATA;
  logic [CMD_W:0]   DBGCMD;
  logic [CNT_W-1:0] PASS_CNT, FAIL_CNT;

  dbg_cmd_sequencer #(.CMD_W(CMD_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .PULSE_CYC(PULSE),
    .GAP_CYC(GAPC), .TIMEOUT_CYC(TO), .CNT_W(CNT_W), .HALT_ON_ERR(1'b1)) dut (
    .CLK(CLK), .NRST(NRST), .ENABLE(ENABLE), .CLR(CLR), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA), .DBGRUNNING(DBGRUNNING), .DBGERROR(DBGERROR),
    .PORESETN(PORESETN), .DBGCMD(DBGCMD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .TIMEOUT(TIMEOUT), .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Tester configuration (written only by the main flow).
  int t_delay = 5, t_hold = 20;
  bit t_err = 0, t_never = 0, rnd = 0;

  initial begin
    int tick, d, h;
    bit act, pb, e, nv;
    DBGRUNNING = 0; DBGERROR = 0; act = 0; pb = 0; tick = 0; d = 0; h = 0; e = 0; nv = 0;
    forever begin
      @(negedge CLK);
      if (DBGCMD[CMD_W] && !pb) begin
        if (rnd) begin
          d  = $urandom_range(0, 30);
          h  = ($urandom_range(0, 7) == 0) ? 130 : $urandom_range(1, 40);
          e  = ($urandom_range(0, 3) == 0);
          nv = ($urandom_range(0, 9) == 0);
        end else begin
          d = t_delay; h = t_hold; e = t_err; nv = t_never;
        end
        act = 1; tick = 0;
      end else if (act) tick++;
      pb = DBGCMD[CMD_W];
      if (!NRST) act = 0;
      DBGRUNNING = act && !nv && tick >= d && tick < d + h;
      DBGERROR   = e;
    end
  end

  // Behavioural model: a command queue plus the current phase and its age.
  int mq[$];
  int m_por = 0, m_ph = P_RST, m_age = 0, m_code = 0, m_pass = 0, m_fail = 0;
  bit m_err = 0, m_to = 0, m_done = 0;

  task automatic model_step();
    int nph; bit fin, bad, tmo, rdy;
    if (!NRST) begin
      mq.delete(); m_por = 0; m_ph = P_RST; m_age = 0; m_code = 0;
      m_pass = 0; m_fail = 0; m_err = 0; m_to = 0; m_done = 0;
      return;
    end
    rdy = (m_por >= SYNC) && (mq.size() < DEPTH);
    nph = m_ph; fin = 0; bad = 0; tmo = 0;
    case (m_ph)
      P_RST:  if (m_por >= SYNC) nph = P_IDLE;
      P_IDLE: if (ENABLE && mq.size() > 0) begin m_code = mq.pop_front(); nph = P_STR; end
      P_STR:  if (m_age == PULSE - 1) nph = P_RUN;
      P_RUN:  if (DBGRUNNING) nph = P_DW;
              else if (m_age == TO - 1) begin fin = 1; bad = 1; tmo = 1; end
      P_DW:   if (!DBGRUNNING) begin fin = 1; bad = DBGERROR; end
              else if (m_age == TO - 1) begin fin = 1; bad = 1; tmo = 1; end
      P_GAP:  if (m_age == GAPC - 1) nph = P_IDLE;
      default: if (CLR) nph = P_IDLE;
    endcase
    if (fin) nph = bad ? P_HALT : P_GAP;
    if (CMD_VALID && rdy) mq.push_back(int'(CMD_DATA));
    m_done = fin;
    if (CLR) begin m_pass = 0; m_fail = 0; m_err = 0; m_to = 0; end
    else if (fin && bad) begin m_err = 1; m_to = m_to | tmo; if (m_fail < CMAX) m_fail++; end
    else if (fin) begin if (m_pass < CMAX) m_pass++; end
    m_age = (nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
    if (m_por < SYNC) m_por++;
  endtask

  initial forever begin @(posedge CLK); model_step(); end

  // Compare process plus strobe/DONE bookkeeping for the directed checks.
  int cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, cur_len = 0;
  int strobe_q[$], len_q[$];
  initial begin
    bit pb, epor;
    pb = 0;
    forever begin
      @(posedge CLK); #1; cyc++;
      epor = (m_por >= SYNC);
      check("PORESETN", PORESETN, epor);
      check("CMD_READY", CMD_READY, epor && mq.size() < DEPTH);
      check("DBGCMD", DBGCMD, (m_ph == P_STR) ? ((1 << CMD_W) | m_code) : 0);
      check("BUSY", BUSY, !(m_ph == P_RST || m_ph == P_IDLE));
      check("DONE", DONE, m_done);
      check("ERR", ERR, m_err);
      check("TIMEOUT", TIMEOUT, m_to);
      check("PASS_CNT", PASS_CNT, m_pass);
      check("FAIL_CNT", FAIL_CNT, m_fail);
      if (DBGCMD[CMD_W] && !pb) begin strobe_q.push_back(int'(DBGCMD)); start_cyc = cyc; cur_len = 1; end
      else if (DBGCMD[CMD_W]) cur_len++;
      else if (pb) len_q.push_back(cur_len);
      pb = DBGCMD[CMD_W];
      if (DONE) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic push(input int c);
    int n;
    @(negedge CLK); CMD_VALID = 1; CMD_DATA = CMD_W'(c); n = 0;
    while (!CMD_READY && n < 300) begin @(negedge CLK); n++; end
    @(negedge CLK); CMD_VALID = 0;
  endtask

  task automatic wait_done(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin @(negedge CLK); n++; end
    check(nm, done_cnt, target);
  endtask

  task automatic pulse_clr();
    @(negedge CLK); CLR = 1;
    @(negedge CLK); CLR = 0;
  endtask

  initial begin
    int n, bs, bd;
    NRST = 0; ENABLE = 0; CLR = 0; CMD_VALID = 0; CMD_DATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_poresetn", PORESETN, 0);
    check("rst_ready", CMD_READY, 0);
    check("rst_dbgcmd", DBGCMD, 0);
    check("rst_busy", BUSY, 0);

    // PORESETN must rise on the 4th edge after release.
    @(negedge CLK); NRST = 1; n = 0;
    do begin @(posedge CLK); #1; n++; end while (!PORESETN && n < 20);
    check("por_edges", n, 4);

    // Two passing commands.
    ENABLE = 1; bs = strobe_q.size(); bd = done_cnt;
    push(0); push(1);
    wait_done("wait_pass2", bd + 2, 600);
    repeat (20) @(negedge CLK);
    check("p_code0", strobe_q[bs], 'h20);
    check("p_len0", len_q[bs], 16);
    check("p_code1", strobe_q[bs+1], 'h21);
    check("p_len1", len_q[bs+1], 16);
    check("p_pass", PASS_CNT, 2);
    check("p_dones", done_cnt - bd, 2);

    // Failure halts with a second command queued.
    pulse_clr();
    t_err = 1; bs = strobe_q.size(); bd = done_cnt;
    push(3); push(4);
    wait_done("wait_fail", bd + 1, 300);
    repeat (40) @(negedge CLK);
    check("h_fail", FAIL_CNT, 1);
    check("h_err", ERR, 1);
    check("h_busy", BUSY, 1);
    check("h_nostrobe", strobe_q.size(), bs + 1);
    t_err = 0;
    pulse_clr();
    check("h_clr_err", ERR, 0);
    wait_done("wait_after_clr", bd + 2, 300);
    check("h_second", strobe_q[bs+1], 'h24);

    // Tester never runs: DONE 116 cycles after strobe start.
    repeat (12) @(negedge CLK);
    t_never = 1; bd = done_cnt;
    push(5);
    wait_done("wait_to", bd + 1, 400);
    check("to_latency", done_cyc - start_cyc, 116);
    check("to_flag", TIMEOUT, 1);
    t_never = 0;
    ENABLE = 0;
    pulse_clr();

    // Fill the FIFO while pops are blocked; the 9th push is dropped.
    bs = strobe_q.size(); bd = done_cnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      if (i == 8) check("full_ready", CMD_READY, 0);
      CMD_VALID = 1; CMD_DATA = CMD_W'(10 + i);
    end
    @(negedge CLK); CMD_VALID = 0;
    ENABLE = 1;
    wait_done("wait_eight", bd + 8, 2000);
    repeat (60) @(negedge CLK);
    check("eight_strobes", strobe_q.size() - bs, 8);
    for (int i = 0; i < 8; i++) check("eight_code", strobe_q[bs+i], 'h20 | (10 + i));
    check("pass_sat", PASS_CNT, CMAX);

    // Reset mid WAIT_DONE aborts the command with no DONE.
    t_hold = 40;
    push(2); n = 0;
    while (!(DBGCMD == 0 && DBGRUNNING) && n < 200) begin @(negedge CLK); n++; end
    repeat (3) @(negedge CLK);
    NRST = 0; #1;
    check("ar_dbgcmd", DBGCMD, 0);
    check("ar_pass", PASS_CNT, 0);
    check("ar_por", PORESETN, 0);
    check("ar_busy", BUSY, 0);
    bd = done_cnt;
    @(negedge CLK); NRST = 1;
    repeat (60) @(negedge CLK);
    check("ar_nodone", done_cnt, bd);
    t_hold = 20;

    // Randomised traffic, model-checked every cycle.
    rnd = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      CMD_VALID = ($urandom_range(0, 3) == 0);
      CMD_DATA  = CMD_W'($urandom);
      ENABLE    = ($urandom_range(0, 7) != 0);
      CLR       = ($urandom_range(0, 60) == 0);
      NRST      = ($urandom_range(0, 1500) != 0);
    end
    @(negedge CLK); CMD_VALID = 0; CLR = 0; NRST = 1;
    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbg_cmd_sequencer.md
DBG_CMD_SEQUENCER -- requirements
Module: dbg_cmd_sequencer

Interface
REQ-001 Parameter CMD_W, 5, debug command code width; DBGCMD is CMD_W+1 bits wide.
REQ-002 Parameter DEPTH, 8, command FIFO depth (power of 2, >=2).
REQ-003 Parameter SYNC_STAGES, 4, reset synchroniser length (>=2).
REQ-004 Parameter PULSE_CYC, 16, cycles the command strobe is held.
REQ-005 Parameter GAP_CYC, 8, idle cycles between commands.
REQ-006 Parameter TIMEOUT_CYC, 65535, max cycles in each wait state; CNT_W, 8, pass/fail counter width.
REQ-007 Parameter HALT_ON_ERR, 1, stop the sequence on the first failed or timed-out command.
REQ-008 CLK  input  1  sequencer clock.
REQ-009 NRST  input  1  reset, asynchronous, active-low.
REQ-010 ENABLE  input  1  permit FIFO pops.
REQ-011 CLR  input  1  synchronous clear of status; releases HALT.
REQ-012 CMD_VALID / CMD_READY / CMD_DATA  input / output / CMD_W  command push handshake.
REQ-013 DBGRUNNING / DBGERROR  input  1 each  debug tester status, synchronous to CLK.
REQ-014 PORESETN  output  1  synchronised reset to the debug tester.
REQ-015 DBGCMD  output  CMD_W+1  {start bit, code} to the tester.
REQ-016 BUSY, DONE, ERR, TIMEOUT  output  1 each  state != IDLE/RST_WAIT; one-cycle pulse per completed command; sticky fail; sticky timeout.
REQ-017 PASS_CNT / FAIL_CNT  output  CNT_W each  completed-command tallies.

Function
REQ-018 PORESETN SHALL assert asynchronously with NRST and deassert after SYNC_STAGES rising CLK edges of NRST high (a shift of 1s).
REQ-019 A push SHALL occur when CMD_VALID and CMD_READY are both high; CMD_READY = !full; push while full is ignored.
REQ-020 States: RST_WAIT, IDLE, ISSUE, WAIT_RUN, WAIT_DONE, GAP, HALT.
REQ-021 RST_WAIT -> IDLE on the first cycle PORESETN is high.
REQ-022 IDLE: if ENABLE and the FIFO is not empty, pop the head -> ISSUE; the pop takes effect on the same edge.
REQ-023 ISSUE: DBGCMD = {1, code} for exactly PULSE_CYC cycles, then DBGCMD = 0 -> WAIT_RUN.
REQ-024 WAIT_RUN: on DBGRUNNING=1 -> WAIT_DONE; after TIMEOUT_CYC cycles -> timeout event.
REQ-025 WAIT_DONE: on DBGRUNNING=0, sample DBGERROR: 0 increments PASS_CNT, 1 increments FAIL_CNT and sets ERR; DONE pulses; after TIMEOUT_CYC cycles -> timeout event.
REQ-026 Timeout event: set TIMEOUT and ERR, increment FAIL_CNT, pulse DONE.
REQ-027 After a completed command: if it failed and HALT_ON_ERR=1 -> HALT, else -> GAP.
REQ-028 GAP: hold GAP_CYC cycles -> IDLE.
REQ-029 HALT: DBGCMD=0; no pops; leave to IDLE only on CLR.
REQ-030 CLR SHALL zero PASS_CNT, FAIL_CNT, ERR and TIMEOUT in any state; it SHALL NOT flush the FIFO or abort an in-flight command.
REQ-031 Counters SHALL saturate at 2^CNT_W-1.
REQ-032 The wait counter SHALL be $clog2(TIMEOUT_CYC+1) bits wide and SHALL restart on every state entry.
REQ-033 ENABLE low SHALL only block new pops; an in-flight command completes.

Reset
REQ-034 NRST low SHALL force state RST_WAIT, an empty FIFO, PORESETN=0, DBGCMD=0, CMD_READY=0, BUSY/DONE/ERR/TIMEOUT=0 and counters=0.
REQ-035 CMD_READY SHALL rise only once PORESETN is high.
REQ-036 NRST asserted mid-command SHALL abort the command immediately with no DONE pulse.

Structure
REQ-037 Package dbg_seq_pkg SHALL hold the state enum, the start-bit index and the default parameter constants.
REQ-038 The FIFO SHALL be the sub-module dbg_cmd_fifo (DEPTH, CMD_W; push/pop/full/empty); all else stays in one module.

Verification
REQ-039 Push 0x00 then 0x01, ENABLE=1; the tester raises DBGRUNNING 5 cycles after each strobe and holds it 20 cycles with DBGERROR=0 -> DBGCMD=0x20 then 0x21, each for 16 cycles; PASS_CNT=2; two DONE pulses.
REQ-040 Command 0x03 with DBGERROR=1, HALT_ON_ERR=1, a second command queued -> FAIL_CNT=1, ERR=1, state HALT, second command not issued until CLR.
REQ-041 DBGRUNNING never rises, TIMEOUT_CYC=100 -> DONE exactly 116 cycles after strobe start; TIMEOUT=1.
REQ-042 Push 9 commands with DEPTH=8 and ENABLE=0 -> CMD_READY=0 after the 8th push; the 9th is dropped; 8 commands execute once ENABLE=1.
REQ-043 Deassert NRST with SYNC_STAGES=4 -> PORESETN rises on the 4th edge; NRST pulsed low during WAIT_DONE -> DBGCMD=0, counters=0, no DONE.
